// File: rtl/rotary_param_ctrl.sv
// Rotary-encoder parameter controller: browse four registers, edit the selected
// one with speed-dependent step size, and accept host writes at any time.
module rotary_param_ctrl #(
  parameter int WIDTH       = 8,
  parameter int MAX_VAL     = 255,
  parameter int WRAP        = 0,
  parameter int FAST_WINDOW = 50000,
  parameter int FAST_STEP   = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cnt,
  input  logic               i_cnt_cw,
  input  logic               i_sel,
  input  logic               i_load,
  input  logic [1:0]         i_load_idx,
  input  logic [WIDTH-1:0]   i_load_data,
  output logic               o_mode,
  output logic [1:0]         o_idx,
  output logic [4*WIDTH-1:0] o_vals,
  output logic [WIDTH-1:0]   o_sel_val,
  output logic               o_changed
);

  localparam int TW = (FAST_WINDOW < 2) ? 1 : $clog2(FAST_WINDOW + 1);
  localparam logic [TW-1:0]    FW_T   = TW'(FAST_WINDOW);
  localparam logic [WIDTH:0]   MAX_X  = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] FAST_S = WIDTH'(FAST_STEP);
  localparam logic [WIDTH-1:0] ONE_S  = WIDTH'(1'b1);

  typedef enum logic {ST_BROWSE = 1'b0, ST_EDIT = 1'b1} state_t;

  state_t           state_r, state_s;
  logic [1:0]       idx_r, idx_s;
  logic [WIDTH-1:0] vals_r [4];
  logic [WIDTH-1:0] vals_s [4];
  logic [TW-1:0]    timer_r, timer_s;
  logic             changed_r, changed_s;
  logic [WIDTH-1:0] sel_val_r;
  logic [WIDTH-1:0] step_s;
  logic [WIDTH-1:0] stepped_s;
  logic [WIDTH-1:0] load_val_s;

  // One encoder step on a register value; WIDTH+1 bits so the sum never overflows.
  function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] val,
                                                input logic [WIDTH-1:0] step,
                                                input logic             up);
    logic [WIDTH:0] v;
    logic [WIDTH:0] s;
    logic [WIDTH:0] modv;
    logic [WIDTH:0] r;
    v    = {1'b0, val};
    s    = {1'b0, step};
    modv = MAX_X + {{WIDTH{1'b0}}, 1'b1};
    if (up) begin
      r = v + s;
      if (r > MAX_X) begin
        if (WRAP != 0) begin
          r = r - modv;
        end else begin
          r = MAX_X;
        end
      end else begin
        r = v + s;
      end
    end else begin
      if (v < s) begin
        if (WRAP != 0) begin
          r = v + modv - s;
        end else begin
          r = {(WIDTH + 1){1'b0}};
        end
      end else begin
        r = v - s;
      end
    end
    return r[WIDTH-1:0];
  endfunction

  // Host data clamped into the legal register range
  always_comb begin
    load_val_s = i_load_data;
    if ({1'b0, i_load_data} > MAX_X) begin
      load_val_s = MAX_X[WIDTH-1:0];
    end else begin
      load_val_s = i_load_data;
    end
  end

  // Next-state, register update and change-pulse logic
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    vals_s    = vals_r;
    changed_s = 1'b0;
    step_s    = (timer_r < FW_T) ? FAST_S : ONE_S;
    stepped_s = step_val(vals_r[idx_r], step_s, i_cnt_cw);
    if (timer_r < FW_T) begin
      timer_s = timer_r + TW'(1'b1);
    end else begin
      timer_s = FW_T;
    end

    case (state_r)
      ST_BROWSE: begin
        if (i_sel) begin
          state_s = ST_EDIT;
          timer_s = FW_T;
        end else if (i_cnt) begin
          idx_s = i_cnt_cw ? (idx_r + 2'd1) : (idx_r - 2'd1);
        end else begin
          idx_s = idx_r;
        end
      end
      ST_EDIT: begin
        if (i_sel) begin
          state_s = ST_BROWSE;
        end else if (i_cnt) begin
          timer_s = {TW{1'b0}};
          // A same-cycle host write to this register takes precedence
          if (!(i_load && (i_load_idx == idx_r))) begin
            vals_s[idx_r] = stepped_s;
            changed_s     = (stepped_s != vals_r[idx_r]);
          end else begin
            changed_s = 1'b0;
          end
        end else begin
          state_s = ST_EDIT;
        end
      end
      default: begin
        state_s = ST_BROWSE;
      end
    endcase

    if (i_load) begin
      vals_s[i_load_idx] = load_val_s;
    end else begin
      vals_s[i_load_idx] = vals_s[i_load_idx];
    end
  end

  // Registered state with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r   <= ST_BROWSE;
      idx_r     <= 2'd0;
      vals_r    <= '{default: '0};
      timer_r   <= FW_T;
      changed_r <= 1'b0;
      sel_val_r <= '0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      vals_r    <= vals_s;
      timer_r   <= timer_s;
      changed_r <= changed_s;
      sel_val_r <= vals_s[idx_s];
    end
  end

  assign o_mode    = (state_r == ST_EDIT);
  assign o_idx     = idx_r;
  assign o_vals    = {vals_r[3], vals_r[2], vals_r[1], vals_r[0]};
  assign o_sel_val = sel_val_r;
  assign o_changed = changed_r;

endmodule

// File: tb/tb_rotary_param_ctrl.sv
// Bench for rotary_param_ctrl: a saturating and a wrapping instance share the
// same stimulus and are compared to a cycle-level arithmetic model.
module tb_rotary_param_ctrl;

  localparam int FW = 20;

  logic       clk = 1'b0;
  logic       rst_n, cnt, cw, sel, load;
  logic [1:0] lidx;
  logic [7:0] ldata;

  logic        s_mode, w_mode, s_chg, w_chg;
  logic [1:0]  s_idx, w_idx;
  logic [31:0] s_vals, w_vals;
  logic [7:0]  s_sel, w_sel;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int e_mode, e_idx, e_last;
  int e_vals [2][4];
  int e_chg  [2];

  always #5 clk = ~clk;

  rotary_param_ctrl #(.WIDTH(8), .MAX_VAL(255), .WRAP(0), .FAST_WINDOW(FW), .FAST_STEP(4)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_cnt(cnt), .i_cnt_cw(cw), .i_sel(sel),
    .i_load(load), .i_load_idx(lidx), .i_load_data(ldata),
    .o_mode(s_mode), .o_idx(s_idx), .o_vals(s_vals), .o_sel_val(s_sel), .o_changed(s_chg));

  rotary_param_ctrl #(.WIDTH(8), .MAX_VAL(255), .WRAP(1), .FAST_WINDOW(FW), .FAST_STEP(4)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n), .i_cnt(cnt), .i_cnt_cw(cw), .i_sel(sel),
    .i_load(load), .i_load_idx(lidx), .i_load_data(ldata),
    .o_mode(w_mode), .o_idx(w_idx), .o_vals(w_vals), .o_sel_val(w_sel), .o_changed(w_chg));

  function automatic int apply(input int wrap, input int v, input int delta);
    int t;
    t = v + delta;
    if (wrap != 0) return ((t % 256) + 256) % 256;
    if (t > 255) return 255;
    if (t < 0) return 0;
    return t;
  endfunction

  // Model of one clock edge, using the inputs currently driven.
  task automatic mdl_edge();
    int s, nv;
    if (!rst_n) begin
      e_mode = 0; e_idx = 0; e_last = -1;
      for (int d = 0; d < 2; d++) begin
        e_chg[d] = 0;
        for (int k = 0; k < 4; k++) e_vals[d][k] = 0;
      end
      return;
    end
    e_chg[0] = 0; e_chg[1] = 0;
    if (sel) begin
      e_mode = 1 - e_mode;
      if (e_mode == 1) e_last = -1;
    end else if (cnt) begin
      if (e_mode == 0) begin
        e_idx = cw ? (e_idx + 1) % 4 : (e_idx + 3) % 4;
      end else begin
        // idle cycles strictly between the two accepted pulses
        s = (e_last >= 0 && (cyc - e_last - 1) < FW) ? 4 : 1;
        e_last = cyc;
        if (!(load && int'(lidx) == e_idx)) begin
          for (int d = 0; d < 2; d++) begin
            nv = apply(d, e_vals[d][e_idx], cw ? s : -s);
            e_chg[d] = (nv != e_vals[d][e_idx]) ? 1 : 0;
            e_vals[d][e_idx] = nv;
          end
        end
      end
    end
    if (load) begin
      for (int d = 0; d < 2; d++) e_vals[d][lidx] = int'(ldata);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic c, input logic w,
                       input logic l, input logic [1:0] li, input logic [7:0] ld);
    rst_n = r; sel = s; cnt = c; cw = w; load = l; lidx = li; ldata = ld;
    mdl_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 8'd5);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    n_cmp++;
    if ({s_mode, s_idx, s_chg, s_sel, s_vals} !== 44'd0) begin
      n_bad++; $display("FAIL reset_sat got %h want 0", {s_mode, s_idx, s_chg, s_sel, s_vals});
    end
    n_cmp++;
    if ({w_mode, w_idx, w_chg, w_sel, w_vals} !== 44'd0) begin
      n_bad++; $display("FAIL reset_wrap got %h want 0", {w_mode, w_idx, w_chg, w_sel, w_vals});
    end
  endtask

  task automatic test_browse();
    int want [5] = '{1, 2, 3, 0, 3};
    logic dir [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, dir[i], 1'b0, 2'd0, 8'd0);
      n_cmp++;
      if (s_idx !== 2'(want[i]) || s_vals !== 32'd0 || s_chg !== 1'b0) begin
        n_bad++; $display("FAIL browse_step%0d got idx %0d vals %h want idx %0d vals 0", i, s_idx, s_vals, want[i]);
      end
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
    n_cmp++;
    if (s_idx !== 2'd0) begin
      n_bad++; $display("FAIL browse_back got %0d want 0", s_idx);
    end
  endtask

  task automatic test_slow_edit();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    n_cmp++;
    if (s_mode !== 1'b1) begin
      n_bad++; $display("FAIL edit_entry got %0b want 1", s_mode);
    end
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
      n_cmp++;
      if (s_vals[7:0] !== 8'(k) || s_sel !== 8'(k) || s_chg !== 1'b1) begin
        n_bad++; $display("FAIL slow_step%0d got val %0d sel %0d chg %0b want %0d/%0d/1", k, s_vals[7:0], s_sel, s_chg, k, k);
      end
      idle(1);
      n_cmp++;
      if (s_chg !== 1'b0) begin
        n_bad++; $display("FAIL slow_pulse%0d got chg %0b want 0", k, s_chg);
      end
      idle(98);
    end
  endtask

  task automatic test_fast_edit();
    int want [3] = '{1, 5, 9};
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
      n_cmp++;
      if (s_vals[7:0] !== 8'(want[i]) || s_chg !== 1'b1) begin
        n_bad++; $display("FAIL fast_step%0d got %0d chg %0b want %0d/1", i, s_vals[7:0], s_chg, want[i]);
      end
      idle(9);
    end
  endtask

  task automatic test_bounds();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'd254);
    n_cmp++;
    if (s_vals[7:0] !== 8'd254 || s_chg !== 1'b0) begin
      n_bad++; $display("FAIL load254 got %0d chg %0b want 254/0", s_vals[7:0], s_chg);
    end
    idle(30);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
    n_cmp++;
    if (s_vals[7:0] !== 8'd255 || s_chg !== 1'b1 || w_vals[7:0] !== 8'd255 || w_chg !== 1'b1) begin
      n_bad++; $display("FAIL bound_up1 got sat %0d/%0b wrap %0d/%0b want 255/1 255/1", s_vals[7:0], s_chg, w_vals[7:0], w_chg);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
    n_cmp++;
    if (s_vals[7:0] !== 8'd255 || s_chg !== 1'b0 || w_vals[7:0] !== 8'd3 || w_chg !== 1'b1) begin
      n_bad++; $display("FAIL bound_up2 got sat %0d/%0b wrap %0d/%0b want 255/0 3/1", s_vals[7:0], s_chg, w_vals[7:0], w_chg);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'd255);
    idle(30);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
    n_cmp++;
    if (s_vals[7:0] !== 8'd255 || s_chg !== 1'b0 || w_vals[7:0] !== 8'd0 || w_chg !== 1'b1) begin
      n_bad++; $display("FAIL wrap_top got sat %0d/%0b wrap %0d/%0b want 255/0 0/1", s_vals[7:0], s_chg, w_vals[7:0], w_chg);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'd0);
    idle(30);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    n_cmp++;
    if (s_vals[7:0] !== 8'd0 || s_chg !== 1'b0 || w_vals[7:0] !== 8'd255 || w_chg !== 1'b1) begin
      n_bad++; $display("FAIL bound_down got sat %0d/%0b wrap %0d/%0b want 0/0 255/1", s_vals[7:0], s_chg, w_vals[7:0], w_chg);
    end
  endtask

  task automatic test_collision();
    idle(30);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 8'd7);
    n_cmp++;
    if (s_vals[7:0] !== 8'd7 || s_chg !== 1'b0 || w_vals[7:0] !== 8'd7 || w_chg !== 1'b0) begin
      n_bad++; $display("FAIL load_wins got %0d/%0b %0d/%0b want 7/0", s_vals[7:0], s_chg, w_vals[7:0], w_chg);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 8'd85);
    n_cmp++;
    if (s_vals[7:0] !== 8'd11 || s_vals[23:16] !== 8'd85 || s_chg !== 1'b1) begin
      n_bad++; $display("FAIL load_other got r0 %0d r2 %0d chg %0b want 11/85/1", s_vals[7:0], s_vals[23:16], s_chg);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
    n_cmp++;
    if (s_mode !== 1'b0 || s_idx !== 2'd0 || s_vals !== 32'h0055_000B || s_chg !== 1'b0) begin
      n_bad++; $display("FAIL sel_cnt got mode %0b idx %0d vals %h chg %0b want 0/0/0055000b/0", s_mode, s_idx, s_vals, s_chg);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 8'd99);
    n_cmp++;
    if ({s_mode, s_idx, s_chg, s_sel, s_vals} !== 44'd0 || w_vals !== 32'd0) begin
      n_bad++; $display("FAIL reset_mid got %h want 0", {s_mode, s_idx, s_chg, s_sel, s_vals});
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
    n_cmp++;
    if (s_idx !== 2'd1 || s_mode !== 1'b0) begin
      n_bad++; $display("FAIL after_reset got idx %0d mode %0b want 1/0", s_idx, s_mode);
    end
  endtask

  task automatic test_random();
    logic [43:0] got, exp;
    logic        burst;
    logic [7:0]  ld;
    burst = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) burst = ~burst;
      case ($urandom_range(0, 4))
        0: ld = 8'd0;
        1: ld = 8'd255;
        2: ld = 8'd254;
        default: ld = 8'($urandom_range(0, 255));
      endcase
      drive(($urandom_range(0, 299) != 0),
            ($urandom_range(0, 24) == 0),
            burst ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 11) == 0),
            2'($urandom_range(0, 3)), ld);
      for (int d = 0; d < 2; d++) begin
        if (d == 0) got = {s_mode, s_idx, s_chg, s_sel, s_vals};
        else        got = {w_mode, w_idx, w_chg, w_sel, w_vals};
        exp = {1'(e_mode), 2'(e_idx), 1'(e_chg[d]), 8'(e_vals[d][e_idx]),
               8'(e_vals[d][3]), 8'(e_vals[d][2]), 8'(e_vals[d][1]), 8'(e_vals[d][0])};
        n_cmp++;
        if (got !== exp) begin
          n_bad++; $display("FAIL random cyc %0d dut %0d got %h want %h", cyc, d, got, exp);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; cnt = 1'b0; cw = 1'b0; load = 1'b0; lidx = 2'd0; ldata = 8'd0;
    test_reset();
    test_browse();
    test_slow_edit();
    test_fast_edit();
    test_bounds();
    test_collision();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rotary_param_ctrl.md
ROTARY_PARAM_CTRL -- requirements
Module: rotary_param_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each parameter register.
REQ-002 Parameter MAX_VAL, default 255, upper bound of every register; lower bound is 0; MAX_VAL < 2^WIDTH.
REQ-003 Parameter WRAP, default 0; 0 = saturate at bounds, 1 = wrap modulo (MAX_VAL+1).
REQ-004 Parameter FAST_WINDOW, default 50000, step-interval threshold in i_clk cycles for acceleration.
REQ-005 Parameter FAST_STEP, default 4, step magnitude when accelerated (1 <= FAST_STEP <= MAX_VAL).
REQ-006 i_clk  input  1  sole clock; all logic on rising edge.
REQ-007 i_rst_n  input  1  synchronous active-low reset.
REQ-008 i_cnt  input  1  one-cycle detent pulse from encoder driver.
REQ-009 i_cnt_cw  input  1  direction qualifier, valid with i_cnt; 1 = clockwise (increment), 0 = decrement.
REQ-010 i_sel  input  1  one-cycle, pre-debounced push-button pulse.
REQ-011 i_load  input  1  one-cycle host write strobe.
REQ-012 i_load_idx  input  2  host write target register.
REQ-013 i_load_data  input  WIDTH  host write data.
REQ-014 o_mode  output  1  0 = BROWSE, 1 = EDIT.
REQ-015 o_idx  output  2  currently selected register.
REQ-016 o_vals  output  4*WIDTH  packed registers, reg k at bits [k*WIDTH +: WIDTH].
REQ-017 o_sel_val  output  WIDTH  value of register o_idx.
REQ-018 o_changed  output  1  one-cycle pulse when any register value actually changes via encoder.

Function
REQ-019 FSM states BROWSE and EDIT; i_sel pulse toggles state on the next edge.
REQ-020 BROWSE: i_cnt with cw=1 -> o_idx+1, cw=0 -> o_idx-1, always wrapping modulo 4; registers unchanged.
REQ-021 EDIT: i_cnt adjusts register o_idx by step S: +S if cw=1, -S if cw=0.
REQ-022 S = FAST_STEP when the interval since the previous accepted i_cnt in EDIT is < FAST_WINDOW cycles, else 1.
REQ-023 Interval timer resets to 0 on every accepted EDIT i_cnt, increments otherwise, saturates at FAST_WINDOW; it is forced to FAST_WINDOW on entry to EDIT so the first step is always 1.
REQ-024 WRAP=0: result clamps to 0 / MAX_VAL; WRAP=1: result = (value ± S) mod (MAX_VAL+1); arithmetic uses WIDTH+1 bits, no overflow.
REQ-025 All outputs registered; register/o_idx/o_mode update one cycle after the input pulse; o_sel_val reflects new o_idx or value in the same cycle those update.
REQ-026 o_changed asserts in the cycle the new value appears, only if new value != old (clamped step at bound gives no pulse).
REQ-027 i_sel and i_cnt in same cycle: mode toggles, encoder step dropped.
REQ-028 i_load in any state writes i_load_data (clamped to MAX_VAL) to reg i_load_idx; o_changed not asserted for loads.
REQ-029 i_load and EDIT step on same register in same cycle: load wins, step dropped, timer still resets; different registers: both apply.
REQ-030 i_cnt_cw is ignored when i_cnt is 0.

Reset
REQ-031 While i_rst_n=0 at an edge: state BROWSE, o_idx=0, all registers 0, o_changed=0, timer=FAST_WINDOW.
REQ-032 Reset asserted mid-operation overrides all same-cycle inputs; first accepted input is the edge after i_rst_n returns high.

Verification
REQ-033 Reset, then 3 cw pulses in BROWSE -> o_idx=3; one more cw -> o_idx=0; one ccw -> o_idx=3.
REQ-034 i_sel, then cw pulses spaced 100000 cycles on reg 0 -> values 1,2,3, o_changed pulse each.
REQ-035 EDIT, cw pulses spaced 10 cycles -> 1, 5, 9 (defaults), first step 1.
REQ-036 WRAP=0, load 254 into reg 0, fast cw pair -> 255 then 255, second without o_changed; ccw at 0 stays 0; WRAP=1 build: 255 +1 -> 0.
REQ-037 Same cycle i_load(idx 0, 7) and EDIT cw on reg 0 -> reg0=7, no o_changed; same cycle i_sel+i_cnt -> mode toggles, o_idx/values unchanged.
REQ-038 Assert i_rst_n=0 for one cycle during EDIT with nonzero registers -> all REQ-031 values next cycle.
